// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the fetch queue.
//
// Contents:
//   FQ_DEPTH   default number of queue entries (power of two, 2..16)
//   FQ_XLEN    address / instruction width
//   FQ_DROP_W  width of the counter of responses still owed for flushed
//              requests; sized for up to 255 requests in flight at memory
//   fq_entry_t one queue entry {pc, instr, filled}
//
// Optional feature macro used by fetch_queue: FETCH_QUEUE_PERF_EN.
package fetch_pkg;

  localparam int FQ_DEPTH  = 4;
  localparam int FQ_XLEN   = 32;
  localparam int FQ_DROP_W = 8;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- in-order instruction fetch queue between the fetch-stage PC
// and decode.
//
// An entry is allocated (pc recorded, filled=0) when an instruction memory
// request fires, filled in order by the returning responses, and released at
// the head when decode accepts it. A flush (redirect) empties the queue and
// remembers how many responses are still owed for the discarded requests so
// they can be thrown away as they return.
//
// Ports:
//   clock               single clock, all state on posedge
//   reset               asynchronous, active-low
//   io_pc               current fetch PC (used as request address)
//   io_flush            redirect: clears the queue, drops in-flight work
//   io_stall_en         hold the fetch PC (no request fired this cycle)
//   io_imem_req_valid   request valid
//   io_imem_req_ready   memory accepts request
//   io_imem_req_addr    request address (= io_pc)
//   io_imem_resp_valid  in-order response, no backpressure
//   io_imem_resp_data   returned instruction
//   io_out_valid        head entry filled and presented to decode
//   io_out_ready        decode accepts head
//   io_out_pc           head entry PC
//   io_out_instr        head entry instruction
//   io_perf_stall_cnt   saturating count of stall cycles (only with
//                       FETCH_QUEUE_PERF_EN defined)
//
// Configuration macro: FETCH_QUEUE_PERF_EN adds io_perf_stall_cnt.
// XLEN must equal fetch_pkg::FQ_XLEN because entries use fq_entry_t.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  input  logic            io_flush,
  output logic            io_stall_en,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [XLEN-1:0] io_out_instr
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     io_perf_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t entries [DEPTH];

  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [PW-1:0]        fill_ptr;
  logic [CW-1:0]        count;
  // requests of the live queue still waiting for their response
  logic [CW-1:0]        outstanding;
  // responses owed for requests discarded by a flush
  logic [FQ_DROP_W-1:0] drop_cnt;

  logic                 req_valid;
  logic                 req_fire;
  logic                 out_valid;
  logic                 out_fire;
  logic                 resp_fill;
  logic                 resp_drop;
  logic [FQ_DROP_W-1:0] owed;
  logic [FQ_DROP_W-1:0] flush_drop;

  // Allocation looks only at the registered count, so a slot freed by a
  // pop in the same cycle is not reused until the next cycle. Gating with
  // reset keeps the request low while reset is held.
  assign req_valid = reset && (count < CW'(DEPTH)) && !io_flush;
  assign req_fire  = req_valid && io_imem_req_ready;
  assign out_valid = (count != '0) && entries[head].filled;
  assign out_fire  = out_valid && io_out_ready;

  // Owed responses are consumed first; anything beyond what is owed or
  // outstanding has no matching request and is ignored.
  assign resp_drop = io_imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = io_imem_resp_valid && (drop_cnt == '0) && (outstanding != '0);

  // Everything awaiting a response at a flush becomes owed; a response
  // arriving in the flush cycle already pays one of them off.
  always_comb begin
    owed       = drop_cnt + FQ_DROP_W'(outstanding) + FQ_DROP_W'(req_fire);
    flush_drop = owed;
    if (io_imem_resp_valid && (owed != '0)) begin
      flush_drop = owed - FQ_DROP_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else if (io_flush) begin
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= flush_drop;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      // Pop, allocate and fill never touch the same slot in one cycle:
      // allocate needs a non-full queue, pop a filled head, fill an
      // allocated but unfilled slot.
      if (out_fire) begin
        entries[head].filled <= 1'b0;
        head                 <= head + PW'(1);
      end
      if (req_fire) begin
        entries[tail].pc     <= io_pc;
        entries[tail].filled <= 1'b0;
        tail                 <= tail + PW'(1);
      end
      if (resp_fill) begin
        entries[fill_ptr].instr  <= io_imem_resp_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - FQ_DROP_W'(1);
      end
      count       <= count + CW'(req_fire) - CW'(out_fire);
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fill);
    end
  end

  assign io_imem_req_valid = req_valid;
  assign io_imem_req_addr  = io_pc;
  assign io_stall_en       = !req_fire;
  assign io_out_valid      = out_valid;
  assign io_out_pc         = entries[head].pc;
  assign io_out_instr      = entries[head].instr;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if (io_stall_en && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

  assign io_perf_stall_cnt = perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed bench for fetch_queue (DEPTH=4, XLEN=32).
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising edge. Memory responses are driven by hand.
// With FETCH_QUEUE_PERF_EN defined the stall counter is also exercised.
module tb_fetch_queue;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] io_pc = '0;
  logic            io_flush = 1'b0;
  logic            io_stall_en;
  logic            io_imem_req_valid;
  logic            io_imem_req_ready = 1'b0;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid = 1'b0;
  logic [XLEN-1:0] io_imem_resp_data = '0;
  logic            io_out_valid;
  logic            io_out_ready = 1'b0;
  logic [XLEN-1:0] io_out_pc;
  logic [XLEN-1:0] io_out_instr;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]     io_perf_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_pc              (io_pc),
    .io_flush           (io_flush),
    .io_stall_en        (io_stall_en),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pc          (io_out_pc),
    .io_out_instr       (io_out_instr)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .io_perf_stall_cnt  (io_perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs (called at the falling edge) and let them settle.
  task automatic set(input logic [31:0] pc, input logic rdy, input logic rv,
                     input logic [31:0] rd, input logic ordy, input logic fl);
    io_pc              = pc;
    io_imem_req_ready  = rdy;
    io_imem_resp_valid = rv;
    io_imem_resp_data  = rd;
    io_out_ready       = ordy;
    io_flush           = fl;
    #1;
  endtask

  task automatic nxt;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held
    #1;
    chk("rst_req_valid", io_imem_req_valid, 0);
    chk("rst_stall", io_stall_en, 1);
    chk("rst_out_valid", io_out_valid, 0);
    @(negedge clock);
    reset = 1'b1;

    // stream: 1-cycle memory, decode always ready
    set(32'h0, 1, 0, 0, 1, 0);
    chk("st_req_valid", io_imem_req_valid, 1);
    chk("st_stall", io_stall_en, 0);
    chk("st_addr", io_imem_req_addr, 32'h0);
    chk("st_out_valid0", io_out_valid, 0);
    nxt;
    set(32'h4, 1, 1, 32'hA000_0000, 1, 0);
    chk("st_out_valid1", io_out_valid, 0);
    nxt;
    set(32'h8, 1, 1, 32'hA000_0001, 1, 0);
    chk("st_out_valid2", io_out_valid, 1);
    chk("st_pc0", io_out_pc, 32'h0);
    chk("st_in0", io_out_instr, 32'hA000_0000);
    nxt;
    set(32'hC, 0, 1, 32'hA000_0002, 1, 0);
    chk("st_stall_nordy", io_stall_en, 1);
    chk("st_pc1", io_out_pc, 32'h4);
    chk("st_in1", io_out_instr, 32'hA000_0001);
    nxt;
    set(32'hC, 0, 0, 0, 1, 0);
    chk("st_out_valid4", io_out_valid, 1);
    chk("st_pc2", io_out_pc, 32'h8);
    chk("st_in2", io_out_instr, 32'hA000_0002);
    nxt;
    set(32'hC, 0, 0, 0, 1, 0);
    chk("st_empty", io_out_valid, 0);
    nxt;

    // full: decode stalled, four requests fill the queue (pointers wrap)
    set(32'h10, 1, 0, 0, 0, 0); nxt;
    set(32'h14, 1, 1, 32'hF0, 0, 0); nxt;
    set(32'h18, 1, 1, 32'hF1, 0, 0); nxt;
    set(32'h1C, 1, 1, 32'hF2, 0, 0);
    chk("full_req_valid3", io_imem_req_valid, 1);
    nxt;
    set(32'h20, 1, 1, 32'hF3, 0, 0);
    chk("full_req_valid", io_imem_req_valid, 0);
    chk("full_stall", io_stall_en, 1);
    nxt;
    set(32'h20, 1, 0, 0, 1, 0);
    chk("full_req_valid_pop", io_imem_req_valid, 0);
    chk("full_pc0", io_out_pc, 32'h10);
    chk("full_in0", io_out_instr, 32'hF0);
    nxt;
    set(32'h20, 1, 0, 0, 0, 0);
    chk("full_refill_valid", io_imem_req_valid, 1);
    chk("full_refill_stall", io_stall_en, 0);
    nxt;
    set(32'h24, 1, 1, 32'hF4, 0, 0);
    chk("full_one_only", io_imem_req_valid, 0);
    nxt;
    set(32'h24, 0, 0, 0, 1, 0);
    chk("drain_pc1", io_out_pc, 32'h14);
    chk("drain_in1", io_out_instr, 32'hF1);
    nxt;
    set(32'h24, 0, 0, 0, 1, 0);
    chk("drain_pc2", io_out_pc, 32'h18);
    nxt;
    set(32'h24, 0, 0, 0, 1, 0);
    chk("drain_pc3", io_out_pc, 32'h1C);
    chk("drain_in3", io_out_instr, 32'hF3);
    nxt;
    set(32'h24, 0, 0, 0, 1, 0);
    chk("drain_valid4", io_out_valid, 1);
    chk("drain_pc4", io_out_pc, 32'h20);
    chk("drain_in4", io_out_instr, 32'hF4);
    nxt;
    set(32'h24, 0, 0, 0, 1, 0);
    chk("drain_empty", io_out_valid, 0);
    nxt;

    // flush with two requests in flight, redirect to 0x100
    set(32'h40, 1, 0, 0, 0, 0); nxt;
    set(32'h44, 1, 0, 0, 0, 0); nxt;
    set(32'h48, 1, 0, 0, 0, 1);
    chk("fl_req_blocked", io_imem_req_valid, 0);
    nxt;
    set(32'h100, 1, 1, 32'hDEAD_0000, 0, 0);
    chk("fl_drop2", dut.drop_cnt, 2);
    chk("fl_empty", io_out_valid, 0);
    chk("fl_req_ok", io_imem_req_valid, 1);
    nxt;
    set(32'h104, 0, 1, 32'hDEAD_0001, 0, 0);
    chk("fl_drop1", dut.drop_cnt, 1);
    chk("fl_noshow1", io_out_valid, 0);
    nxt;
    set(32'h104, 0, 1, 32'h1100_0000, 0, 0);
    chk("fl_drop0", dut.drop_cnt, 0);
    chk("fl_noshow2", io_out_valid, 0);
    nxt;
    set(32'h104, 0, 0, 0, 1, 0);
    chk("fl_new_valid", io_out_valid, 1);
    chk("fl_new_pc", io_out_pc, 32'h100);
    chk("fl_new_in", io_out_instr, 32'h1100_0000);
    nxt;
    set(32'h104, 0, 0, 0, 1, 0);
    chk("fl_after_pop", io_out_valid, 0);
    nxt;

    // flush with the only response arriving in the same cycle
    set(32'h200, 1, 0, 0, 0, 0); nxt;
    set(32'h204, 0, 1, 32'hBEEF_0000, 1, 1); nxt;
    set(32'h204, 0, 0, 0, 1, 0);
    chk("flr_out_valid", io_out_valid, 0);
    chk("flr_drop", dut.drop_cnt, 0);
    nxt;
    set(32'h204, 0, 1, 32'hBEEF_0001, 1, 0);
    nxt;
    set(32'h204, 0, 0, 0, 1, 0);
    chk("flr_stray", io_out_valid, 0);
    nxt;

    // asynchronous reset with three entries queued
    set(32'h300, 1, 0, 0, 0, 0); nxt;
    set(32'h304, 1, 1, 32'hC000_0000, 0, 0); nxt;
    set(32'h308, 1, 1, 32'hC000_0001, 0, 0); nxt;
    set(32'h30C, 0, 0, 0, 0, 0);
    chk("ar_pre_valid", io_out_valid, 1);
    chk("ar_pre_pc", io_out_pc, 32'h300);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", io_out_valid, 0);
    chk("ar_req_valid", io_imem_req_valid, 0);
    chk("ar_stall", io_stall_en, 1);
    @(negedge clock);
    reset = 1'b1;
    set(32'h30C, 0, 1, 32'hC000_0002, 1, 0);
    nxt;
    set(32'h30C, 0, 0, 0, 1, 0);
    chk("ar_stray", io_out_valid, 0);
    chk("ar_req_again", io_imem_req_valid, 1);
    nxt;

`ifdef FETCH_QUEUE_PERF_EN
    // stall counter: 10 stalled cycles after a fresh reset, then saturation
    set(32'h0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("perf_reset", io_perf_stall_cnt, 0);
    for (int i = 0; i < 10; i++) nxt;
    chk("perf_10", io_perf_stall_cnt, 10);
    dut.perf_stall_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) nxt;
    chk("perf_sat", io_perf_stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
